// File: rtl/seq_mult_sgn_pkg.sv
// Shared definitions for the sequential signed/unsigned multiplier.
package seq_mult_sgn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PROD_SCALE = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int prod_width(input int width);
        return PROD_SCALE * width;
    endfunction

endpackage

// File: rtl/seq_mult_row.sv
// Ripple add/subtract of one partial-product row into the upper accumulator.
module seq_mult_row
    import seq_mult_sgn_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] row,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic [N-1:0] opnd;

    assign opnd = row ^ {N{sub}};

    // Each bit derives its carry-in from the previous cell, so no carry-out is left dangling.
    for (genvar i = 0; i < N; i++) begin : g_fa
        logic cin;
        if (i == 0) begin : g_lsb
            assign cin = sub;
        end else begin : g_rip
            assign cin = (acc[i-1] & opnd[i-1]) | (g_fa[i-1].cin & (acc[i-1] ^ opnd[i-1]));
        end
        assign sum[i] = acc[i] ^ opnd[i] ^ cin;
    end

endmodule

// File: rtl/seq_mult_sgn.sv
// Sequential multiplier: one partial-product row per clock, ready/valid on both sides.
module seq_mult_sgn
    import seq_mult_sgn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic                           in_sgn,
    input  logic                           abort,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [prod_width(WIDTH)-1:0]   out_p
);
    // state | meaning
    // IDLE  | waiting for operands
    // RUN   | accumulating one partial-product row per clock
    // DONE  | holding the product until out_ready
    localparam int CW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic             sgn_q;
    logic [WIDTH:0]   upper_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH:0]   row, sum, upper_nx;
    logic [WIDTH-1:0] lower_nx;
    logic             accept, last, step, sub;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign step   = (state_q == RUN) & ~abort;

    // The lower half starts out holding b; its LSB selects the row, product bits shift in from the top.
    assign row = lower_q[0] ? {sgn_q & a_q[WIDTH-1], a_q} : '0;
    assign sub = sgn_q & last;

    seq_mult_row #(.N(WIDTH + 1)) u_row (
        .acc (upper_q),
        .row (row),
        .sub (sub),
        .sum (sum)
    );

    assign upper_nx = {sgn_q & sum[WIDTH], sum[WIDTH:1]};
    assign lower_nx = {sum[0], lower_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            sgn_q     <= 1'b0;
            upper_q   <= '0;
            lower_q   <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == DONE);
            if (accept) begin
                a_q     <= in_a;
                sgn_q   <= in_sgn;
                upper_q <= '0;
                lower_q <= in_b;
                cnt_q   <= '0;
            end else if (step) begin
                upper_q <= upper_nx;
                lower_q <= lower_nx;
                cnt_q   <= cnt_q + CW'(1);
                if (last) out_p <= {upper_nx[WIDTH-1:0], lower_nx};
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_sgn.sv
// Bench for seq_mult_sgn: WIDTH=4 and WIDTH=8 instances checked against a cycle-level reference model.
module tb_seq_mult_sgn;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v4 = 0, s4 = 0, ab4 = 0, or4 = 1;
    logic [3:0] a4 = 0, b4 = 0;
    logic       ir4, ov4;
    logic [7:0] p4;

    logic       v8 = 0, s8 = 0, ab8 = 0, or8 = 1;
    logic [7:0] a8 = 0, b8 = 0;
    logic       ir8, ov8;
    logic [15:0] p8;

    seq_mult_sgn #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_sgn(s4), .abort(ab4), .out_valid(ov4), .out_ready(or4), .out_p(p4)
    );

    seq_mult_sgn #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_sgn(s8), .abort(ab8), .out_valid(ov8), .out_ready(or8), .out_p(p8)
    );

    logic [1:0]       vld_v, ordy_v, abt_v, sgn_v, ir_v, ov_v;
    logic [1:0][7:0]  a_v, b_v;
    logic [1:0][15:0] p_v;
    assign vld_v  = {v8, v4};
    assign ordy_v = {or8, or4};
    assign abt_v  = {ab8, ab4};
    assign sgn_v  = {s8, s4};
    assign ir_v   = {ir8, ir4};
    assign ov_v   = {ov8, ov4};
    assign a_v    = {a8, {4'h0, a4}};
    assign b_v    = {b8, {4'h0, b4}};
    assign p_v    = {p8, {8'h00, p4}};

    int errors = 0;
    int checks = 0;

    // Reference model state: edges left until the product appears, current output, pending product.
    int     rem[2];
    bit     mv[2];
    longint mp[2];
    longint pend[2];
    int     dut_hs[2];

    function automatic int wd(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic longint ref_prod(input int w, input longint a, input longint b, input bit s);
        longint m, x, y;
        m = (longint'(1) << w) - 1;
        x = a & m;
        y = b & m;
        if (s && x >= (longint'(1) << (w - 1))) x -= longint'(1) << w;
        if (s && y >= (longint'(1) << (w - 1))) y -= longint'(1) << w;
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic bit m_rdy(input int d, input bit ordy);
        return (rem[d] == 0) && (!mv[d] || ordy);
    endfunction

    task automatic check(input string name, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (width %0d) at %0t: got 0x%0h, expected 0x%0h", name, wd(d), $time, act, exp);
        end
    endtask

    task automatic monitor();
        bit               srst;
        logic [1:0]       sv, so, sab, ss, sov;
        logic [1:0][7:0]  sa, sb;
        forever begin
            @(negedge clk);
            #1;
            srst = rst_n; sv = vld_v; so = ordy_v; sab = abt_v; ss = sgn_v;
            sa = a_v; sb = b_v; sov = ov_v;
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n || !srst) begin
                    rem[d] = 0;
                    mv[d]  = 1'b0;
                    mp[d]  = 0;
                end else begin
                    bit acc;
                    acc = sv[d] && m_rdy(d, so[d]);
                    if (sov[d] && so[d]) dut_hs[d]++;
                    if (rem[d] > 0) begin
                        if (sab[d]) begin
                            rem[d] = 0;
                        end else begin
                            rem[d]--;
                            if (rem[d] == 0) begin
                                mv[d] = 1'b1;
                                mp[d] = pend[d];
                            end
                        end
                    end else if (mv[d] && so[d]) begin
                        mv[d] = 1'b0;
                    end
                    if (acc) begin
                        pend[d] = ref_prod(wd(d), longint'(sa[d]), longint'(sb[d]), ss[d]);
                        rem[d]  = wd(d);
                    end
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                check("out_valid", d, longint'(ov_v[d]), longint'(mv[d]));
                check("out_p", d, longint'(p_v[d]), mp[d]);
                check("in_ready", d, longint'(ir_v[d]), longint'(m_rdy(d, ordy_v[d])));
            end
        end
    endtask

    task automatic set_in(input int d, input bit v, input logic [7:0] a, input logic [7:0] b, input bit s);
        if (d == 0) begin
            v4 = v; a4 = a[3:0]; b4 = b[3:0]; s4 = s;
        end else begin
            v8 = v; a8 = a; b8 = b; s8 = s;
        end
    endtask

    task automatic set_ab(input int d, input bit v);
        if (d == 0) ab4 = v;
        else        ab8 = v;
    endtask

    task automatic set_or(input int d, input bit v);
        if (d == 0) or4 = v;
        else        or8 = v;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input bit s,
                         input bit with_abort, output int waited);
        set_in(d, 1'b1, a, b, s);
        set_ab(d, with_abort);
        waited = 0;
        while (!ir_v[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", d, longint'(ir_v[d]), 1);
        @(negedge clk);
        set_in(d, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        set_ab(d, 1'b0);
    endtask

    task automatic wait_ov(input int d, output int n);
        n = 0;
        while (!ov_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", d, longint'(ov_v[d]), 1);
    endtask

    task automatic expect_p(input int d, input longint lit);
        int n;
        wait_ov(d, n);
        check("latency", d, n, wd(d));
        check("lit_p", d, longint'(p_v[d]), lit);
    endtask

    initial begin
        int w, n, hs0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_p", 0, longint'(p4), 0);
        check("rst_valid", 1, longint'(ov8), 0);
        check("rst_p", 1, longint'(p8), 0);
        check("rst_ready", 1, longint'(ir8), 1);
        @(negedge clk);

        // Hand-computed WIDTH=4 products
        issue(0, 8'h8, 8'h8, 1, 0, w); expect_p(0, 'h40);
        issue(0, 8'h8, 8'h7, 1, 0, w); expect_p(0, 'hC8);
        issue(0, 8'h3, 8'hB, 1, 0, w); expect_p(0, 'hF1);
        issue(0, 8'hF, 8'hF, 0, 0, w); expect_p(0, 'hE1);
        issue(0, 8'h0, 8'h9, 0, 0, w); expect_p(0, 'h00);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    issue(0, 8'(a), 8'(b), 1'(s), 0, w);
                    wait_ov(0, n);
                end

        // Back-to-back WIDTH=8 with out_ready held high
        @(negedge clk);
        hs0 = dut_hs[1];
        issue(1, 8'h7F, 8'h80, 1, 0, w); expect_p(1, 'hC080);
        issue(1, 8'hFF, 8'hFF, 0, 0, w); check("b2b_wait", 1, w, 0); expect_p(1, 'hFE01);
        issue(1, 8'h80, 8'h80, 1, 0, w); check("b2b_wait", 1, w, 0); expect_p(1, 'h4000);
        issue(1, 8'hFF, 8'h01, 1, 0, w); check("b2b_wait", 1, w, 0); expect_p(1, 'hFFFF);
        issue(1, 8'h12, 8'h34, 0, 0, w); check("b2b_wait", 1, w, 0); expect_p(1, 'h03A8);
        repeat (2) @(negedge clk);
        check("b2b_count", 1, dut_hs[1] - hs0, 5);

        // Backpressure
        set_or(1, 0);
        issue(1, 8'h05, 8'h07, 0, 0, w);
        wait_ov(1, n);
        for (int i = 0; i < 5; i++) begin
            check("bp_p", 1, longint'(p8), 'h23);
            check("bp_valid", 1, longint'(ov8), 1);
            check("bp_ready", 1, longint'(ir8), 0);
            @(negedge clk);
        end
        set_or(1, 1);
        @(negedge clk);
        check("bp_release_valid", 1, longint'(ov8), 0);
        check("bp_release_ready", 1, longint'(ir8), 1);

        // Abort at cnt=2, then accept together with abort in IDLE
        issue(1, 8'h0B, 8'h0D, 0, 0, w);
        repeat (2) @(negedge clk);
        set_ab(1, 1);
        @(negedge clk);
        set_ab(1, 0);
        check("abort_ready", 1, longint'(ir8), 1);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", 1, longint'(ov8), 0);
            @(negedge clk);
        end
        issue(1, 8'h0B, 8'h0D, 0, 1, w); expect_p(1, 'h008F);

        // Abort while holding a product is ignored
        @(negedge clk);
        set_or(1, 0);
        issue(1, 8'hF6, 8'h03, 1, 0, w); expect_p(1, 'hFFE2);
        set_ab(1, 1);
        @(negedge clk);
        set_ab(1, 0);
        check("done_abort_valid", 1, longint'(ov8), 1);
        check("done_abort_p", 1, longint'(p8), 'hFFE2);
        set_or(1, 1);
        @(negedge clk);
        check("done_abort_release", 1, longint'(ov8), 0);

        // Asynchronous reset in the middle of RUN
        issue(1, 8'h33, 8'h44, 0, 0, w);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 1, longint'(ov8), 0);
        check("arst_p", 1, longint'(p8), 0);
        check("arst_ready", 1, longint'(ir8), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1, 8'h33, 8'h44, 0, 0, w); expect_p(1, 'h0D8C);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
